// File: rtl/rq_to_r3_lanes_pkg.sv
// rtl/rq_to_r3_lanes_pkg.sv - shared constants, R3 codes and FSM states for rq_to_r3_lanes
// Purpose: default ring parameters, 2-bit R3 lane codes and the frame FSM state type.
// Ports: none (package).
package rq_r3_pkg;

  localparam int Q      = 5167;
  localparam int P      = 757;
  localparam int W      = 13;
  localparam int HALF_Q = (Q - 1) / 2;

  localparam logic [1:0] R3_ZERO = 2'b00;
  localparam logic [1:0] R3_POS  = 2'b01;
  localparam logic [1:0] R3_NEG  = 2'b11;
  localparam logic [1:0] R3_BAD  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rq_to_r3_lanes_mod3_freeze_lane.sv
// rtl/rq_to_r3_lanes_mod3_freeze_lane.sv - one lane of the 3-stage centre / mod-3 / freeze datapath
// Purpose: S1 centres x into (-(Q-1)/2..(Q-1)/2), S2 takes |c| mod 3, S3 emits the R3 code.
// Ports: clk, rst_n; en1..en3 per-stage load enables shared by all lanes; live marks a
//        real coefficient; x unsigned input; bad (comb) flags live x >= Q; code registered S3 output.
module mod3_freeze_lane #(
  parameter int Q = rq_r3_pkg::Q,
  parameter int W = rq_r3_pkg::W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en1,
  input  logic         en2,
  input  logic         en3,
  input  logic         live,
  input  logic [W-1:0] x,
  output logic         bad,
  output logic [1:0]   code
);
  import rq_r3_pkg::*;

  localparam int HQ = (Q - 1) / 2;

  logic signed [W:0] c1_q, c1_d;
  logic              bad1_q, bad1_d;
  logic [1:0]        m2_q, m2_d;
  logic              neg2_q, neg2_d;
  logic              bad2_q, bad2_d;
  logic [1:0]        code3_q, code3_d;
  logic [W:0]        abs_c;

  always_comb begin
    bad    = live && (x >= W'(Q));
    bad1_d = bad;
    // Dead and out-of-range lanes carry c=0 so only the bad flag decides their code.
    if (!live || bad) begin
      c1_d = '0;
    end else if (x > W'(HQ)) begin
      c1_d = $signed({1'b0, x}) - $signed((W+1)'(Q));
    end else begin
      c1_d = $signed({1'b0, x});
    end

    abs_c  = c1_q[W] ? $unsigned(-c1_q) : $unsigned(c1_q);
    m2_d   = 2'(abs_c % (W+1)'(3));
    neg2_d = c1_q[W];
    bad2_d = bad1_q;

    // m==2 is -1 times the sign, so the result is positive when exactly one of (m==1, c<0) holds... inverted by sign.
    if (bad2_q) begin
      code3_d = R3_BAD;
    end else if (m2_q == 2'd0) begin
      code3_d = R3_ZERO;
    end else if ((m2_q == 2'd1) ^ neg2_q) begin
      code3_d = R3_POS;
    end else begin
      code3_d = R3_NEG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1_q    <= '0;
      bad1_q  <= 1'b0;
      m2_q    <= 2'd0;
      neg2_q  <= 1'b0;
      bad2_q  <= 1'b0;
      code3_q <= R3_ZERO;
    end else begin
      if (en1) begin
        c1_q   <= c1_d;
        bad1_q <= bad1_d;
      end
      if (en2) begin
        m2_q   <= m2_d;
        neg2_q <= neg2_d;
        bad2_q <= bad2_d;
      end
      if (en3) begin
        code3_q <= code3_d;
      end
    end
  end

  assign code = code3_q;

endmodule

// File: rtl/rq_to_r3_lanes.sv
// rtl/rq_to_r3_lanes.sv - streams a P-coefficient Rq polynomial into R3 codes, LANES per beat
// Purpose: frame FSM, beat counter, 3-stage valid chain with bubble compression, sticky err.
// Ports: clk, rst_n; start/abort control; in_valid/in_ready/in_data input stream;
//        out_valid/out_ready/out_data/out_last output stream; busy, done pulse, sticky err.
module rq_to_r3_lanes #(
  parameter int Q     = rq_r3_pkg::Q,
  parameter int P     = rq_r3_pkg::P,
  parameter int W     = rq_r3_pkg::W,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*2-1:0] out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               err
);
  import rq_r3_pkg::*;

  localparam int BEATS = (P + LANES - 1) / LANES;
  localparam int LP    = P - (BEATS - 1) * LANES;
  localparam int CW    = $clog2(BEATS + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic            l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;

  logic            stall, ld1, ld2, ld3, accept, last_in, out_fire;
  logic [LANES-1:0]   lane_live, lane_bad;
  logic [LANES*2-1:0] code_bus;

  always_comb begin
    stall    = v3_q && !out_ready;
    // A stage loads when empty or when the stage after it is moving.
    ld3      = !v3_q || out_ready;
    ld2      = !v2_q || ld3;
    ld1      = !v1_q || ld2;
    in_ready = (state_q == RUN) && (in_cnt_q < CW'(BEATS)) && !stall;
    accept   = in_valid && in_ready;
    last_in  = (in_cnt_q == CW'(BEATS - 1));
    out_fire = v3_q && out_ready;

    v1_d = ld1 ? accept : v1_q;
    l1_d = ld1 ? (accept && last_in) : l1_q;
    v2_d = ld2 ? v1_q : v2_q;
    l2_d = ld2 ? l1_q : l2_q;
    v3_d = ld3 ? v2_q : v3_q;
    l3_d = ld3 ? l2_q : l3_q;

    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    err_d    = err_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = RUN;
          in_cnt_d = '0;
          err_d    = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + 1'b1;
          err_d    = err_q || (|lane_bad);
          if (last_in) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire && l3_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort flushes the pipeline but leaves err for software to read.
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      in_cnt_d = '0;
      done_d   = 1'b0;
      v1_d     = 1'b0;
      v2_d     = 1'b0;
      v3_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      in_cnt_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      l1_q     <= 1'b0;
      l2_q     <= 1'b0;
      l3_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      err_q    <= err_d;
      done_q   <= done_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      l1_q     <= l1_d;
      l2_q     <= l2_d;
      l3_q     <= l3_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    // Only the final beat has dead lanes.
    assign lane_live[i] = (i < LP) || !last_in;

    mod3_freeze_lane #(.Q(Q), .W(W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en1   (ld1),
      .en2   (ld2),
      .en3   (ld3),
      .live  (lane_live[i]),
      .x     (in_data[i*W +: W]),
      .bad   (lane_bad[i]),
      .code  (code_bus[2*i +: 2])
    );
  end

  assign out_valid = v3_q;
  assign out_data  = v3_q ? code_bus : '0;
  assign out_last  = v3_q && l3_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rq_to_r3_lanes.sv
// tb/tb_rq_to_r3_lanes.sv - self-checking bench for rq_to_r3_lanes with scoreboard
module tb_rq_to_r3_lanes;
  localparam int Q     = 5167;
  localparam int P     = 757;
  localparam int W     = 13;
  localparam int LANES = 4;
  localparam int BEATS = (P + LANES - 1) / LANES;
  localparam int LP    = P - (BEATS - 1) * LANES;

  logic clk = 1'b0;
  logic rst_n, start, abort, in_valid, in_ready, out_valid, out_ready, out_last, busy, done, err;
  logic [LANES*W-1:0] in_data;
  logic [LANES*2-1:0] out_data;

  logic s2_start, s2_in_valid, s2_in_ready, s2_out_valid, s2_out_last, s2_busy, s2_done, s2_err;
  logic [LANES*W-1:0] s2_in_data;
  logic [LANES*2-1:0] s2_out_data;

  always #5 clk = ~clk;

  rq_to_r3_lanes #(.Q(Q), .P(P), .W(W), .LANES(LANES)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  // Second instance with P divisible by LANES: last beat is full.
  rq_to_r3_lanes #(.Q(Q), .P(8), .W(W), .LANES(LANES)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(s2_start), .abort(1'b0),
    .in_valid(s2_in_valid), .in_ready(s2_in_ready), .in_data(s2_in_data),
    .out_valid(s2_out_valid), .out_ready(1'b1), .out_data(s2_out_data), .out_last(s2_out_last),
    .busy(s2_busy), .done(s2_done), .err(s2_err)
  );

  typedef struct { logic [LANES*2-1:0] data; logic last; } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int in_beat = 0;
  int out_beats = 0;
  logic stall_prev = 1'b0;
  logic [LANES*2-1:0] held_data;
  logic [LANES*2-1:0] last_out_data;

  function automatic logic [1:0] ref_code(input int x);
    int c, r;
    if (x >= Q) return 2'b10;
    c = (x > (Q - 1) / 2) ? x - Q : x;
    r = ((c % 3) + 3) % 3;
    if (r == 0) return 2'b00;
    if (r == 1) return 2'b01;
    return 2'b11;
  endfunction

  function automatic logic [LANES*W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  function automatic logic [LANES*W-1:0] rand_beat();
    return pack4($urandom_range(0, Q-1), $urandom_range(0, Q-1), $urandom_range(0, Q-1), $urandom_range(0, Q-1));
  endfunction

  // Scoreboard: push golden codes on input handshake, compare on output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!out_valid || out_data !== held_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b data=%h required valid=1 data=%h", out_valid, out_data, held_data);
        end
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra_beat: data=%h with empty scoreboard", out_data);
        end else begin
          e = sb_q.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL sb_beat: data=%h last=%0b required data=%h last=%0b", out_data, out_last, e.data, e.last);
          end
        end
        out_beats++;
        last_out_data = out_data;
      end
      if (in_valid && in_ready) begin
        e.last = (in_beat == BEATS - 1);
        for (int i = 0; i < LANES; i++)
          e.data[2*i +: 2] = (!e.last || i < LP) ? ref_code(int'(in_data[i*W +: W])) : 2'b00;
        sb_q.push_back(e);
        in_beat++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    in_beat = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic abort_frame();
    abort = 1'b1;
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    stall_prev = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({in_ready, out_valid, out_data, out_last, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0b ov=%0b od=%h ol=%0b busy=%0b done=%0b err=%0b required all 0",
               in_ready, out_valid, out_data, out_last, busy, done, err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_values();
    out_ready = 1'b1;
    start_frame();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: busy=%0b in_ready=%0b required 1 1", busy, in_ready);
    end
    in_data = pack4(0, 1, 2, 4);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_t1: out_valid=%0b required 0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_t2: out_valid=%0b required 0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h74) begin
      errors++;
      $display("FAIL small_values: valid=%0b data=%h required 1 74", out_valid, out_data);
    end
    in_data = pack4(2583, 2584, 5166, 5165);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h70) begin
      errors++;
      $display("FAIL centre_edge: valid=%0b data=%h required 1 70", out_valid, out_data);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_before: err=%0b required 0", err); end
    in_data = pack4(1, 2, 5200, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_set: err=%0b required 1", err); end
    step();
    step();
    checks++;
    if (out_data !== 8'h2D) begin errors++; $display("FAIL bad_lane: data=%h required 2d", out_data); end
    abort_frame();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL abort_keeps_err: busy=%0b done=%0b err=%0b required 0 0 1", busy, done, err);
    end
    start_frame();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear_on_start: err=%0b required 0", err); end
    abort_frame();
  endtask

  task automatic test_start_abort_together();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_abort: busy=%0b required 0", busy); end
  endtask

  task automatic run_frame(input int pv, input int pr, output bit timed_out);
    int sent;
    bit acc, lastout;
    logic [LANES*W-1:0] data;
    timed_out = 1'b1;
    out_beats = 0;
    sent = 0;
    data = rand_beat();
    start_frame();
    for (int cyc = 0; cyc < 5000; cyc++) begin
      in_valid  = (sent < BEATS) && ($urandom_range(0, 99) < pv);
      in_data   = data;
      out_ready = ($urandom_range(0, 99) < pr);
      #1;
      acc     = in_valid && in_ready;
      lastout = out_valid && out_ready && out_last;
      step();
      if (acc) begin
        sent++;
        data = rand_beat();
      end
      if (lastout) begin
        timed_out = 1'b0;
        break;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_full_frame();
    bit to;
    run_frame(100, 100, to);
    checks++;
    if (to) begin errors++; $display("FAIL full_timeout: no last beat within budget"); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: done=%0b required 1", done); end
    checks++;
    if (out_beats != BEATS || sb_q.size() != 0) begin
      errors++;
      $display("FAIL full_count: beats=%0d left=%0d required %0d 0", out_beats, sb_q.size(), BEATS);
    end
    checks++;
    if (last_out_data[LANES*2-1:2] !== '0) begin
      errors++;
      $display("FAIL dead_lanes: upper lanes=%h required 0", last_out_data[LANES*2-1:2]);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done: done=%0b busy=%0b required 0 0", done, busy);
    end
  endtask

  task automatic test_throttle();
    bit to;
    run_frame(70, 55, to);
    checks++;
    if (to) begin errors++; $display("FAIL throttle_timeout: no last beat within budget"); end
    checks++;
    if (out_beats != BEATS || sb_q.size() != 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL throttle_count: beats=%0d left=%0d done=%0b required %0d 0 1", out_beats, sb_q.size(), done, BEATS);
    end
    step();
  endtask

  task automatic test_abort_mid();
    bit seen_done;
    out_ready = 1'b1;
    start_frame();
    in_valid = 1'b1;
    for (int b = 0; b < 50; b++) begin
      in_data = rand_beat();
      step();
    end
    abort_frame();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_mid: busy=%0b out_valid=%0b required 0 0", busy, out_valid);
    end
    seen_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done || out_valid) seen_done = 1'b1;
      step();
    end
    checks++;
    if (seen_done) begin errors++; $display("FAIL abort_quiet: done/out_valid seen=1 required 0"); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    start_frame();
    in_valid = 1'b1;
    for (int b = 0; b < 20; b++) begin
      in_data = rand_beat();
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_last, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL async_reset: rdy=%0b ov=%0b od=%h ol=%0b busy=%0b done=%0b err=%0b required all 0",
               in_ready, out_valid, out_data, out_last, busy, done, err);
    end
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    sb_q.delete();
    step();
  endtask

  task automatic test_full_last_beat();
    s2_start = 1'b1;
    step();
    s2_start = 1'b0;
    s2_in_data = pack4(1, 2, 4, 5166);
    s2_in_valid = 1'b1;
    step();
    step();
    s2_in_valid = 1'b0;
    step();
    checks++;
    if (s2_out_valid !== 1'b1 || s2_out_last !== 1'b0 || s2_out_data !== 8'hDD) begin
      errors++;
      $display("FAIL p8_beat0: v=%0b last=%0b data=%h required 1 0 dd", s2_out_valid, s2_out_last, s2_out_data);
    end
    step();
    checks++;
    if (s2_out_valid !== 1'b1 || s2_out_last !== 1'b1 || s2_out_data !== 8'hDD) begin
      errors++;
      $display("FAIL p8_full_last: v=%0b last=%0b data=%h required 1 1 dd", s2_out_valid, s2_out_last, s2_out_data);
    end
    step();
    checks++;
    if (s2_done !== 1'b1) begin errors++; $display("FAIL p8_done: done=%0b required 1", s2_done); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    s2_start = 1'b0; s2_in_valid = 1'b0; s2_in_data = '0;
    test_reset();
    test_values();
    test_start_abort_together();
    test_full_frame();
    test_throttle();
    test_abort_mid();
    test_async_reset();
    test_full_last_beat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
